// File: rtl/ddr2_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_refresh_scheduler
//  Description : AUTO REFRESH scheduler. Times tREFI intervals, accumulates
//                owed refreshes (postponement up to MAX_POSTPONE), requests
//                refresh slots via req/ack and holds the device off for tRFC.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr2_refresh_scheduler #(
    parameter int TREFI_CLK     = 1560,
    parameter int TRFC_CLK      = 26,
    parameter int MAX_POSTPONE  = 8,
    parameter int URGENT_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        ref_ack_i,
    output logic        ref_req_o,
    output logic        ref_urgent_o,
    output logic        trfc_busy_o,
    output logic [3:0]  pending_o,
    output logic        overflow_o,
    output logic        proto_err_o,
    output logic [31:0] refresh_cnt_o
);

    localparam int ICW = (TREFI_CLK > 1) ? $clog2(TREFI_CLK) : 1;
    localparam int TCW = (TRFC_CLK > 1) ? $clog2(TRFC_CLK) : 1;

    localparam logic [ICW-1:0] INT_LAST  = ICW'(TREFI_CLK - 1);
    localparam logic [TCW-1:0] TRFC_LOAD = TCW'(TRFC_CLK - 1);
    localparam logic [3:0]     PEND_MAX  = 4'(MAX_POSTPONE);
    localparam logic [3:0]     PEND_URG  = 4'(URGENT_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_TRFC = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [ICW-1:0] int_cnt;
    logic [TCW-1:0] trfc_cnt;
    logic [TCW-1:0] trfc_nx;
    logic [3:0]     pending;
    logic [3:0]     pending_nx;
    logic           tick;
    logic           ack_ok;

    // Tick fires on the TREFI_CLK-th enabled cycle; acks only count while requesting.
    assign tick   = enable_i && (int_cnt == INT_LAST);
    assign ack_ok = (state == ST_REQ) && ref_ack_i;

    // Interval counter: held at zero while disabled so re-enable restarts a full interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_cnt <= '0;
        end else if (!enable_i || tick) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_cnt + ICW'(1);
        end
    end

    // Next-state, owed-refresh count and tRFC countdown.
    always_comb begin
        state_nx   = state;
        trfc_nx    = trfc_cnt;
        pending_nx = pending;

        // Disabling clears the debt even if an ack is accepted in the same cycle.
        if (!enable_i) begin
            pending_nx = 4'd0;
        end else if (tick && !ack_ok) begin
            pending_nx = (pending == PEND_MAX) ? pending : pending + 4'd1;
        end else if (ack_ok && !tick) begin
            pending_nx = pending - 4'd1;
        end

        case (state)
            ST_IDLE: begin
                if (pending_nx != 4'd0) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_ok) begin
                    state_nx = ST_TRFC;
                    trfc_nx  = TRFC_LOAD;
                end else if (!enable_i) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_TRFC: begin
                // A started tRFC window always runs to completion.
                if (trfc_cnt == '0) begin
                    state_nx = (pending_nx != 4'd0) ? ST_REQ : ST_IDLE;
                end else begin
                    trfc_nx = trfc_cnt - TCW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, pending and tRFC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pending  <= 4'd0;
            trfc_cnt <= '0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            trfc_cnt <= trfc_nx;
        end
    end

    // Sticky error flags and the accepted-refresh counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_o    <= 1'b0;
            proto_err_o   <= 1'b0;
            refresh_cnt_o <= 32'd0;
        end else begin
            if (tick && !ack_ok && (pending == PEND_MAX)) begin
                overflow_o <= 1'b1;
            end
            if (ref_ack_i && (state != ST_REQ)) begin
                proto_err_o <= 1'b1;
            end
            if (ack_ok) begin
                refresh_cnt_o <= refresh_cnt_o + 32'd1;
            end
        end
    end

    // Outputs decoded from registered state only.
    assign ref_req_o    = (state == ST_REQ);
    assign trfc_busy_o  = (state == ST_TRFC);
    assign ref_urgent_o = (pending >= PEND_URG);
    assign pending_o    = pending;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr2_refresh_scheduler
//  Description : Directed self-checking bench for ddr2_refresh_scheduler
//                (TREFI_CLK=100, TRFC_CLK=10, MAX_POSTPONE=8, URGENT_THRESH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_refresh_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic        ref_ack_i = 1'b0;
    logic        ref_req_o;
    logic        ref_urgent_o;
    logic        trfc_busy_o;
    logic [3:0]  pending_o;
    logic        overflow_o;
    logic        proto_err_o;
    logic [31:0] refresh_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ddr2_refresh_scheduler #(
        .TREFI_CLK     (100),
        .TRFC_CLK      (10),
        .MAX_POSTPONE  (8),
        .URGENT_THRESH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .ref_ack_i     (ref_ack_i),
        .ref_req_o     (ref_req_o),
        .ref_urgent_o  (ref_urgent_o),
        .trfc_busy_o   (trfc_busy_o),
        .pending_o     (pending_o),
        .overflow_o    (overflow_o),
        .proto_err_o   (proto_err_o),
        .refresh_cnt_o (refresh_cnt_o)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    // Free-running edge counter used to measure ack spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        enable_i  = 1'b0;
        ref_ack_i = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset    = 1'b0;
        enable_i = 1'b1;
    endtask

    task automatic do_ack();
        ref_ack_i = 1'b1;
        step();
        ref_ack_i = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int n);
        n = 0;
        while (!ref_req_o && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic wait_pend(input logic [3:0] v, input int bound, input string tag);
        int n;
        n = 0;
        while (pending_o != v && n < bound) begin
            step();
            n++;
        end
        chk(tag, pending_o, v);
    endtask

    task automatic wait_idle_busy(output int n);
        n = 0;
        while (trfc_busy_o && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int a_prev;
        int a_now;

        // Reset state
        step();
        chk("rst_req", ref_req_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_busy", trfc_busy_o, 0);
        chk("rst_cnt", refresh_cnt_o, 0);

        // 1: immediate acks, interval and tRFC timing
        restart();
        wait_req(300, n);
        chk("t1_first_req", n, 100);
        chk("t1_pend1", pending_o, 1);
        do_ack();
        a_prev = cyc;
        chk("t1_busy", trfc_busy_o, 1);
        chk("t1_cnt1", refresh_cnt_o, 1);
        wait_idle_busy(n);
        chk("t1_busy_len", n, 10);
        for (int i = 2; i <= 3; i++) begin
            wait_req(300, n);
            do_ack();
            a_now = cyc;
            chk("t1_spacing", a_now - a_prev, 100);
            chk("t1_cnt", refresh_cnt_o, i);
            a_prev = a_now;
        end

        // 2: postpone five refreshes, then drain
        restart();
        for (int k = 1; k <= 5; k++) begin
            wait_pend(4'(k), 150, "t2_pend_up");
            chk("t2_urgent", ref_urgent_o, (k >= 4) ? 1 : 0);
        end
        a_prev = 0;
        for (int k = 5; k >= 1; k--) begin
            wait_req(50, n);
            chk("t2_pend_dn", pending_o, k);
            do_ack();
            a_now = cyc;
            if (k < 5) chk("t2_spacing", a_now - a_prev, 11);
            a_prev = a_now;
        end
        wait_idle_busy(n);
        chk("t2_req_low", ref_req_o, 0);
        chk("t2_pend0", pending_o, 0);
        chk("t2_urgent0", ref_urgent_o, 0);

        // 3: saturation and overflow
        restart();
        wait_pend(4'd8, 900, "t3_pend8");
        repeat (99) step();
        chk("t3_ovf_before", overflow_o, 0);
        chk("t3_pend_before", pending_o, 8);
        step();
        chk("t3_ovf_set", overflow_o, 1);
        chk("t3_pend_sat", pending_o, 8);
        do_ack();
        chk("t3_ovf_sticky", overflow_o, 1);
        chk("t3_pend7", pending_o, 7);

        // 4: ack coincident with a tick
        restart();
        wait_pend(4'd2, 300, "t4_pend2");
        repeat (99) step();
        do_ack();
        chk("t4_pend_hold", pending_o, 2);
        chk("t4_cnt", refresh_cnt_o, 1);
        chk("t4_busy", trfc_busy_o, 1);

        // 5a: ack while idle
        restart();
        do_ack();
        chk("t5a_proto", proto_err_o, 1);
        chk("t5a_pend", pending_o, 0);
        chk("t5a_cnt", refresh_cnt_o, 0);

        // 5b: ack during tRFC
        restart();
        wait_req(300, n);
        do_ack();
        chk("t5b_proto0", proto_err_o, 0);
        step();
        step();
        do_ack();
        chk("t5b_proto1", proto_err_o, 1);
        chk("t5b_cnt", refresh_cnt_o, 1);
        chk("t5b_pend", pending_o, 0);
        n = 4;
        step();
        while (trfc_busy_o && n < 50) begin
            n++;
            step();
        end
        chk("t5b_busy_len", n, 10);

        // 6a: asynchronous reset mid-tRFC
        restart();
        wait_pend(4'd4, 500, "t6_pend4");
        do_ack();
        step();
        chk("t6_pend3", pending_o, 3);
        chk("t6_busy", trfc_busy_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_outs",
            {27'd0, ref_req_o, ref_urgent_o, trfc_busy_o, overflow_o, proto_err_o}, 0);
        chk("t6_async_pend", pending_o, 0);
        chk("t6_async_cnt", refresh_cnt_o, 0);

        // 6b: disable with debt outstanding
        restart();
        wait_pend(4'd3, 400, "t6b_pend3");
        chk("t6b_req", ref_req_o, 1);
        enable_i = 1'b0;
        step();
        chk("t6b_pend0", pending_o, 0);
        chk("t6b_req0", ref_req_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr2_refresh_scheduler.md
Name: ddr2_refresh_scheduler

Overview:
Controller-side AUTO REFRESH scheduler. It times tREFI intervals, accumulates owed refreshes (JEDEC postponement, up to MAX_POSTPONE), and requests refresh slots from the command arbiter via a req/ack handshake. After each issued refresh it holds off the device for tRFC. It sits directly upstream of the arbiter that drives the DDR2 command pads checked by the refresh-interval monitor; with immediate acks, issued refresh spacing equals TREFI_CLK exactly.

Parameters:
TREFI_CLK, 1560, refresh interval in clk cycles (7.8 us at 200 MHz); must be >= 2.
TRFC_CLK, 26, refresh-to-any-command hold-off in clk cycles; must be >= 1.
MAX_POSTPONE, 8, maximum owed refreshes; range 1..15.
URGENT_THRESH, 4, pending count at or above which urgent asserts; range 1..MAX_POSTPONE.

Ports:
clk  input  1  controller clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
enable_i  input  1  scheduler runs only while high (tied to init-done/ready).
ref_ack_i  input  1  one-cycle pulse: arbiter issued AUTO REFRESH this cycle.
ref_req_o  output  1  refresh owed and device free; arbiter must issue REF.
ref_urgent_o  output  1  pending_o >= URGENT_THRESH; arbiter must stop new ACTIVATEs.
trfc_busy_o  output  1  tRFC window active; arbiter must issue no command.
pending_o  output  4  number of owed refreshes.
overflow_o  output  1  sticky: tick arrived with pending already at MAX_POSTPONE.
proto_err_o  output  1  sticky: ref_ack_i received while ref_req_o low.
refresh_cnt_o  output  32  total accepted acks, wraps at 2^32.

Behaviour:
- Reset (async, immediate): all outputs 0; interval counter 0; state IDLE; trfc counter 0. Sticky flags clear only on reset.
- Interval counter, width clog2(TREFI_CLK): increments on each enable_i=1 cycle. Wraps TREFI_CLK-1 -> 0 and asserts an internal tick that same cycle. Tick therefore occurs on the TREFI_CLK-th enabled cycle.
- pending update at each edge, priority order:
  - tick and accepted ack together: unchanged.
  - tick only: +1. If already MAX_POSTPONE, stays saturated and overflow_o sets next cycle.
  - accepted ack only: -1.
- FSM states: IDLE, REQ, TRFC.
  - IDLE: ref_req_o=0. Go to REQ when pending becomes nonzero, so ref_req_o rises the cycle after the tick edge, together with pending_o=1.
  - REQ: ref_req_o=1. ref_ack_i is accepted only here: pending -1, refresh_cnt +1, trfc counter loads TRFC_CLK-1, go to TRFC.
  - TRFC: trfc_busy_o=1, ref_req_o=0. Counter decrements each cycle. When it reaches 0, go to REQ if pending>0 else IDLE. trfc_busy_o is high exactly TRFC_CLK cycles, starting the cycle after the ack edge.
  - Ticks continue counting during TRFC.
- ref_ack_i in IDLE or TRFC: ignored (no count change); proto_err_o sets next cycle.
- ref_urgent_o and ref_req_o are decoded combinationally from registered pending/state; no input-to-output combinational paths.
- enable_i low:
  - Interval counter held at 0, pending cleared to 0, REQ -> IDLE.
  - An in-progress TRFC runs to completion, then goes to IDLE.
  - Re-enable restarts a full TREFI_CLK interval.
- Simultaneous ack and enable_i falling edge: the ack is accepted (counted, TRFC entered), then pending clears.

Test Plan:
1. TREFI_CLK=100, TRFC_CLK=10, ack the cycle after each req -> first ref_req_o 100 cycles after enable, trfc_busy_o high 10 cycles, successive acks exactly 100 cycles apart, refresh_cnt_o 1,2,3.
2. Withhold ack for 5 ticks -> pending_o 1..5, ref_urgent_o rises when pending_o=4. Then ack whenever req is high -> pending counts 5..0, acks spaced 11 cycles apart (10 busy + 1), ref_req_o low at pending 0.
3. Withhold ack for 9 ticks (MAX_POSTPONE=8) -> pending_o saturates at 8, overflow_o rises the cycle after the 9th tick and stays high through later acks.
4. Ack on the same cycle as a tick with pending_o=2 -> pending_o stays 2, refresh_cnt_o +1, FSM enters TRFC.
5. Ack with pending_o=0, and ack during trfc_busy_o -> proto_err_o set, pending_o/refresh_cnt_o unchanged, trfc window length unchanged.
6. Assert reset asynchronously mid-TRFC with pending_o=3 -> all outputs 0 before the next clk edge. Separately, drop enable_i with pending_o=3 -> pending_o 0 next cycle, ref_req_o 0.
